decode_pipe_stage: RTL and testbench

- Parametrised next-generation instruction-decode stage for the 16-bit-instruction pipelined core.
- Contains the register file with optional write-through bypass, the opcode control decode, and immediate extension to DATA_W.
- Adds load-use hazard detection (stall), EX-driven flush, sticky halt, and an owned ID/EX pipeline register, so downstream stages see only registered, valid-qualified outputs.

---
 rtl/decode_pkg.sv | 52 +++++
 rtl/decode_ctrl.sv | 56 +++++
 rtl/decode_pipe_stage.sv | 129 ++++++++++++
 tb/tb_decode_pipe_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, selector
// encodings and the decoded control word.
package decode_pkg;

  // 5-bit major opcodes, instr[15:11]
  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_RTYPE = 5'b11011;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_J     = 5'b00100;

  // Destination register source
  typedef enum logic [1:0] {
    DST_RS  = 2'd0,  // instr[10:8]
    DST_RD  = 2'd1,  // instr[4:2]
    DST_R7  = 2'd2,  // link register
    DST_RT  = 2'd3   // instr[7:5]
  } dst_sel_e;

  // Immediate extraction / extension mode
  typedef enum logic [1:0] {
    IMM_SEXT5  = 2'd0,
    IMM_SEXT8  = 2'd1,
    IMM_ZEXT5  = 2'd2,
    IMM_SEXT11 = 2'd3
  } imm_sel_e;

  // Decoded control word
  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     uses_rs;
    logic     uses_rt;
    dst_sel_e dst_sel;
    imm_sel_e imm_sel;
    logic     is_halt;
    logic     illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    uses_rs: 1'b0, uses_rt: 1'b0,
    dst_sel: DST_RS, imm_sel: IMM_SEXT5,
    is_halt: 1'b0, illegal: 1'b0
  };

endpackage

// File: rtl/decode_ctrl.sv
// Pure combinational opcode to control-word table.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl
);

  // Table lookup; any opcode not listed is flagged illegal
  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    ctrl = CTRL_NONE;
    case (opcode)
      OP_HALT:  ctrl.is_halt = 1'b1;
      OP_NOP:   ;
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.dst_sel   = DST_RT;
        ctrl.imm_sel   = IMM_SEXT5;
      end
      OP_ST: begin
        ctrl.mem_write = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.uses_rt   = 1'b1;
        ctrl.imm_sel   = IMM_SEXT5;
      end
      OP_LD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.dst_sel   = DST_RT;
        ctrl.imm_sel   = IMM_SEXT5;
      end
      OP_LBI: begin
        ctrl.reg_write = 1'b1;
        ctrl.dst_sel   = DST_RS;
        ctrl.imm_sel   = IMM_SEXT8;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.uses_rt   = 1'b1;
        ctrl.dst_sel   = DST_RD;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.dst_sel   = DST_R7;
        ctrl.imm_sel   = IMM_SEXT11;
      end
      OP_J:     ctrl.imm_sel = IMM_SEXT11;
      default:  ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Instruction-decode stage: register file with optional WB bypass, control
// decode, immediate extension, load-use stall, flush, sticky halt/err and
// the ID/EX pipeline register.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BYPASS_EN = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc_inc,
  input  logic              ex_flush,
  input  logic              wb_regWrite,
  input  logic [2:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              idex_valid,
  output logic [DATA_W-1:0] idex_reg1,
  output logic [DATA_W-1:0] idex_reg2,
  output logic [DATA_W-1:0] idex_imm,
  output logic [DATA_W-1:0] idex_pc_inc,
  output logic [2:0]        idex_write_reg,
  output logic              idex_regWrite,
  output logic              idex_memRead,
  output logic              idex_memWrite,
  output logic [4:0]        idex_opcode,
  output logic              halted,
  output logic              err
);

  ctrl_t             ctrl;
  logic [2:0]        rs_sel, rt_sel, dst_reg;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic              hazard, capture, load_valid;

  assign rs_sel = if_instr[10:8];
  assign rt_sel = if_instr[7:5];

  decode_ctrl u_ctrl (
    .opcode (if_instr[15:11]),
    .ctrl   (ctrl)
  );

  // Register file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is small and architecturally required to read
      // 0 after reset, so it is reset explicitly rather than left as RAM.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wb_regWrite) begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      regs[wb_write_reg] <= wb_data;
    end
  end

  // Read ports, optionally forwarding the same-cycle WB write
  assign rd1 = ((BYPASS_EN != 0) && wb_regWrite && (wb_write_reg == rs_sel))
             ? wb_data : regs[rs_sel];
  assign rd2 = ((BYPASS_EN != 0) && wb_regWrite && (wb_write_reg == rt_sel))
             ? wb_data : regs[rt_sel];

  // Destination register and immediate selection
  always_comb begin
    dst_reg = if_instr[10:8];
    imm     = '0;
    case (ctrl.dst_sel)
      DST_RS:  dst_reg = if_instr[10:8];
      DST_RD:  dst_reg = if_instr[4:2];
      DST_R7:  dst_reg = 3'd7;
      DST_RT:  dst_reg = if_instr[7:5];
      default: dst_reg = if_instr[10:8];
    endcase
    case (ctrl.imm_sel)
      IMM_SEXT5:  imm = {{(DATA_W-5){if_instr[4]}},   if_instr[4:0]};
      IMM_SEXT8:  imm = {{(DATA_W-8){if_instr[7]}},   if_instr[7:0]};
      IMM_ZEXT5:  imm = {{(DATA_W-5){1'b0}},          if_instr[4:0]};
      IMM_SEXT11: imm = {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]};
      default:    imm = '0;
    endcase
  end

  // Load-use hazard against the instruction currently in ID/EX
  assign hazard = (HAZARD_EN != 0) && if_valid &&
                  idex_valid && idex_memRead && idex_regWrite &&
                  ((ctrl.uses_rs && (idex_write_reg == rs_sel)) ||
                   (ctrl.uses_rt && (idex_write_reg == rt_sel)));

  // Flush and halt override the stall; only a clean slot captures
  assign id_stall   = hazard && !ex_flush && !halted;
  assign capture    = if_valid && !ex_flush && !halted && !hazard;
  assign load_valid = capture && !ctrl.illegal;

  // ID/EX pipeline register plus sticky halt/err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid     <= 1'b0;
      idex_reg1      <= '0;
      idex_reg2      <= '0;
      idex_imm       <= '0;
      idex_pc_inc    <= '0;
      idex_write_reg <= '0;
      idex_regWrite  <= 1'b0;
      idex_memRead   <= 1'b0;
      idex_memWrite  <= 1'b0;
      idex_opcode    <= '0;
      halted         <= 1'b0;
      err            <= 1'b0;
    end else begin
      idex_valid     <= load_valid;
      idex_regWrite  <= load_valid && ctrl.reg_write;
      idex_memRead   <= load_valid && ctrl.mem_read;
      idex_memWrite  <= load_valid && ctrl.mem_write;
      idex_reg1      <= rd1;
      idex_reg2      <= rd2;
      idex_imm       <= imm;
      idex_pc_inc    <= if_pc_inc;
      idex_write_reg <= dst_reg;
      idex_opcode    <= if_instr[15:11];
      if (load_valid && ctrl.is_halt) halted <= 1'b1;
      if (capture && ctrl.illegal)    err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: default build, a build with bypass
// and hazard logic disabled, and a 32-bit build, all fed the same stimulus.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [31:0] if_pc_inc;
  logic        ex_flush;
  logic        wb_regWrite;
  logic [2:0]  wb_write_reg;
  logic [31:0] wb_data;

  // default build
  logic        a_stall, a_valid, a_rw, a_mr, a_mw, a_halted, a_err;
  logic [15:0] a_reg1, a_reg2, a_imm, a_pc;
  logic [2:0]  a_wr;
  logic [4:0]  a_op;
  // no bypass, no hazard
  logic        b_stall, b_valid, b_rw, b_mr, b_mw, b_halted, b_err;
  logic [15:0] b_reg1, b_reg2, b_imm, b_pc;
  logic [2:0]  b_wr;
  logic [4:0]  b_op;
  // 32-bit datapath
  logic        c_stall, c_valid, c_rw, c_mr, c_mw, c_halted, c_err;
  logic [31:0] c_reg1, c_reg2, c_imm, c_pc;
  logic [2:0]  c_wr;
  logic [4:0]  c_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_pipe_stage u_dut_a (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_inc(if_pc_inc[15:0]), .ex_flush(ex_flush), .wb_regWrite(wb_regWrite),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data[15:0]), .id_stall(a_stall),
    .idex_valid(a_valid), .idex_reg1(a_reg1), .idex_reg2(a_reg2), .idex_imm(a_imm),
    .idex_pc_inc(a_pc), .idex_write_reg(a_wr), .idex_regWrite(a_rw),
    .idex_memRead(a_mr), .idex_memWrite(a_mw), .idex_opcode(a_op),
    .halted(a_halted), .err(a_err)
  );

  decode_pipe_stage #(.DATA_W(16), .BYPASS_EN(0), .HAZARD_EN(0)) u_dut_b (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_inc(if_pc_inc[15:0]), .ex_flush(ex_flush), .wb_regWrite(wb_regWrite),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data[15:0]), .id_stall(b_stall),
    .idex_valid(b_valid), .idex_reg1(b_reg1), .idex_reg2(b_reg2), .idex_imm(b_imm),
    .idex_pc_inc(b_pc), .idex_write_reg(b_wr), .idex_regWrite(b_rw),
    .idex_memRead(b_mr), .idex_memWrite(b_mw), .idex_opcode(b_op),
    .halted(b_halted), .err(b_err)
  );

  decode_pipe_stage #(.DATA_W(32)) u_dut_c (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_inc(if_pc_inc), .ex_flush(ex_flush), .wb_regWrite(wb_regWrite),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data), .id_stall(c_stall),
    .idex_valid(c_valid), .idex_reg1(c_reg1), .idex_reg2(c_reg2), .idex_imm(c_imm),
    .idex_pc_inc(c_pc), .idex_write_reg(c_wr), .idex_regWrite(c_rw),
    .idex_memRead(c_mr), .idex_memWrite(c_mw), .idex_opcode(c_op),
    .halted(c_halted), .err(c_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-assembled encodings
  localparam logic [15:0] I_LBI_R3_80  = 16'hC380; // 11000 011 10000000
  localparam logic [15:0] I_ADDI_5_2_1 = 16'h42A1; // 01000 010 101 00001
  localparam logic [15:0] I_LD_4_1     = 16'h8980; // 10001 001 100 00000
  localparam logic [15:0] I_ADD_6_4_2  = 16'hDC58; // 11011 100 010 110 00
  localparam logic [15:0] I_HALT       = 16'h0000;
  localparam logic [15:0] I_ILLEGAL    = 16'hF800; // 11111
  localparam logic [15:0] I_JAL_400    = 16'h3400; // 00110 10000000000

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc_inc = '0;
    ex_flush = 1'b0; wb_regWrite = 1'b0; wb_write_reg = '0; wb_data = '0;
    step(); step();
    check("rst_valid",  32'(a_valid),  32'd0);
    check("rst_halted", 32'(a_halted), 32'd0);
    check("rst_err",    32'(a_err),    32'd0);
    #3 rst = 1'b0;

    // LBI r3,0x80: sign-extended 8-bit immediate, dst from instr[10:8]
    if_valid = 1'b1; if_instr = I_LBI_R3_80; if_pc_inc = 32'h2;
    step();
    check("lbi_imm",   32'(a_imm),   32'hFF80);
    check("lbi_wr",    32'(a_wr),    32'd3);
    check("lbi_rw",    32'(a_rw),    32'd1);
    check("lbi_valid", 32'(a_valid), 32'd1);
    check("lbi_pc",    32'(a_pc),    32'h2);
    check("lbi_imm32", c_imm,        32'hFFFFFF80);

    // ADDI r5,r2,#1 while WB writes r2=0x1234
    if_instr = I_ADDI_5_2_1; if_pc_inc = 32'h4;
    wb_regWrite = 1'b1; wb_write_reg = 3'd2; wb_data = 32'h1234;
    step();
    check("byp_reg1",   32'(a_reg1), 32'h1234);
    check("nobyp_reg1", 32'(b_reg1), 32'h0);
    check("addi_wr",    32'(a_wr),   32'd5);
    check("addi_imm",   32'(a_imm),  32'h1);
    wb_regWrite = 1'b0;
    step();
    check("nobyp_late", 32'(b_reg1), 32'h1234);

    // LD r4,[r1] then ADD r6,r4,r2 -> one stall; WB writes r4 during it
    if_instr = I_LD_4_1;
    step();
    check("ld_mr", 32'(a_mr), 32'd1);
    check("ld_wr", 32'(a_wr), 32'd4);
    if_instr = I_ADD_6_4_2;
    wb_regWrite = 1'b1; wb_write_reg = 3'd4; wb_data = 32'h55;
    #1;
    check("hz_stall",   32'(a_stall), 32'd1);
    check("nohz_stall", 32'(b_stall), 32'd0);
    step();
    check("hz_bubble",   32'(a_valid), 32'd0);
    check("nohz_valid",  32'(b_valid), 32'd1);
    wb_regWrite = 1'b0;
    #1;
    check("hz_clear", 32'(a_stall), 32'd0);
    step();
    check("add_valid", 32'(a_valid), 32'd1);
    check("add_wr",    32'(a_wr),    32'd6);
    check("add_reg1",  32'(a_reg1),  32'h55);
    check("add_reg2",  32'(a_reg2),  32'h1234);

    // flush beats hazard, and a flushed HALT does not latch
    if_instr = I_LD_4_1;
    step();
    if_instr = I_ADD_6_4_2; ex_flush = 1'b1;
    #1;
    check("fl_stall", 32'(a_stall), 32'd0);
    step();
    check("fl_valid", 32'(a_valid), 32'd0);
    if_instr = I_HALT;
    step();
    check("fl_halt_valid", 32'(a_valid),  32'd0);
    check("fl_halted",     32'(a_halted), 32'd0);
    ex_flush = 1'b0;

    // illegal opcode -> sticky err, passes as a bubble
    if_instr = I_ILLEGAL;
    step();
    check("ill_err",   32'(a_err),   32'd1);
    check("ill_valid", 32'(a_valid), 32'd0);
    check("ill_rw",    32'(a_rw),    32'd0);
    if_valid = 1'b0; if_instr = I_ADDI_5_2_1;
    step();
    check("nov_valid", 32'(a_valid), 32'd0);
    check("err_stick", 32'(a_err),   32'd1);

    // JAL with imm11=0x400
    if_valid = 1'b1; if_instr = I_JAL_400; if_pc_inc = 32'h10;
    step();
    check("jal_imm32", c_imm,        32'hFFFFFC00);
    check("jal_wr32",  32'(c_wr),    32'd7);
    check("jal_rw32",  32'(c_rw),    32'd1);
    check("jal_imm16", 32'(a_imm),   32'hFC00);
    check("jal_pc32",  c_pc,         32'h10);

    // HALT -> sticky, later instructions become bubbles
    if_instr = I_HALT;
    step();
    check("halt_set",   32'(a_halted), 32'd1);
    check("halt_valid", 32'(a_valid),  32'd1);
    if_instr = I_ADDI_5_2_1;
    #1;
    check("halt_nostall", 32'(a_stall), 32'd0);
    step();
    check("halt_bub1", 32'(a_valid), 32'd0);
    step();
    check("halt_bub2",  32'(a_valid),  32'd0);
    check("halt_stick", 32'(a_halted), 32'd1);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("arst_halted", 32'(a_halted), 32'd0);
    check("arst_err",    32'(a_err),    32'd0);
    check("arst_pc",     32'(a_pc),     32'd0);
    check("arst_wr",     32'(a_wr),     32'd0);
    check("arst_imm32",  c_imm,         32'd0);
    rst = 1'b0;
    step();
    check("post_valid", 32'(a_valid), 32'd1);
    check("post_reg1",  32'(a_reg1),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
